// File: rtl/bias_bank_pkg.sv
// Shared definitions for the bias_bank block: default bias word width and
// the load-control FSM state encoding.
package bias_bank_pkg;

  localparam int unsigned BiasW = 18;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

endpackage

// File: rtl/bias_bank_wr_ptr.sv
// Write pointer for the bias store: walks channel-within-group, then group,
// and wraps to entry 0 after the last entry. Clear has priority over increment.
module bias_bank_wr_ptr #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned N_GROUPS     = 4,
  localparam int unsigned NumEntries  = N_GROUPS * N_adder_tree,
  localparam int unsigned IdxW        = (NumEntries > 1) ? $clog2(NumEntries) : 1,
  localparam int unsigned GrpW        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int unsigned ChW         = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  output logic [IdxW-1:0] idx,
  output logic            last
);

  logic [GrpW-1:0] grp_q, grp_d;
  logic [ChW-1:0]  ch_q, ch_d;
  logic            ch_last, grp_last;

  assign ch_last  = (ch_q == ChW'(N_adder_tree - 1));
  assign grp_last = (grp_q == GrpW'(N_GROUPS - 1));
  assign last     = ch_last && grp_last;
  assign idx      = IdxW'(grp_q) * IdxW'(N_adder_tree) + IdxW'(ch_q);

  // Next pointer: clear, or step channel and carry into group with wrap.
  always_comb begin
    grp_d = grp_q;
    ch_d  = ch_q;
    if (clr) begin
      grp_d = '0;
      ch_d  = '0;
    end else if (inc) begin
      if (ch_last) begin
        ch_d  = '0;
        grp_d = grp_last ? '0 : grp_q + GrpW'(1);
      end else begin
        ch_d = ch_q + ChW'(1);
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q <= '0;
      ch_q  <= '0;
    end else begin
      grp_q <= grp_d;
      ch_q  <= ch_d;
    end
  end

endmodule

// File: rtl/bias_bank.sv
// Runtime-loadable multi-group bias store. Biases stream in through a
// valid/ready load port; one whole group is presented per read on q.
// Build option BIAS_BANK_DEFAULT_EN: entries reset to DEFAULT_BIAS and the
// bank comes out of reset already loaded (acts as a constant bias block).
module bias_bank
  import bias_bank_pkg::*;
#(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned N_GROUPS     = 4,
  parameter int unsigned W            = BiasW,
  parameter logic [N_GROUPS*N_adder_tree*W-1:0] DEFAULT_BIAS = '0,
  localparam int unsigned SelW        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_start,
  input  logic                      ld_valid,
  input  logic [W-1:0]              ld_data,
  output logic                      ld_ready,
  output logic                      ld_done,
  input  logic                      grp_valid,
  input  logic [SelW-1:0]           grp_sel,
  output logic                      grp_ready,
  output logic                      q_valid,
  output logic                      q_err,
  output logic [N_adder_tree*W-1:0] q
);

  localparam int unsigned NumEntries = N_GROUPS * N_adder_tree;
  localparam int unsigned IdxW       = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam logic [SelW:0] NumGrp   = (SelW + 1)'(N_GROUPS);

`ifdef BIAS_BANK_DEFAULT_EN
  localparam logic [NumEntries*W-1:0] ResetImage = DEFAULT_BIAS;
  localparam state_e ResetState = StDone;
`else
  localparam logic [NumEntries*W-1:0] ResetImage = '0;
  localparam state_e ResetState = StIdle;
  logic unused_default_bias;
  assign unused_default_bias = ^DEFAULT_BIAS;
`endif

  state_e                    state_q, state_d;
  logic [W-1:0]              mem_q [NumEntries];
  logic [IdxW-1:0]           wr_idx, rd_base;
  logic                      wr_en, wr_last, rd_en, sel_ok;
  logic [N_adder_tree*W-1:0] rd_vec, q_q;
  logic                      q_valid_q, q_err_q;

  assign wr_en  = ld_valid && ld_ready;
  assign rd_en  = grp_valid && grp_ready;
  assign sel_ok = ({1'b0, grp_sel} < NumGrp);

  bias_bank_wr_ptr #(
    .N_adder_tree (N_adder_tree),
    .N_GROUPS     (N_GROUPS)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ld_start),
    .inc   (wr_en),
    .idx   (wr_idx),
    .last  (wr_last)
  );

  // Load FSM next state and handshake outputs; ld_start overrides everything.
  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    ld_done   = 1'b0;
    grp_ready = !ld_start;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        ld_ready  = !ld_start;
        grp_ready = 1'b0;
        if (ld_ready && ld_valid && wr_last) state_d = StDone;
      end
      StDone:  ld_done = 1'b1;
      default: state_d = StIdle;
    endcase
    if (ld_start) state_d = StLoad;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ResetState;
    else        state_q <= state_d;
  end

  // Bias storage: flat register array written one word per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NumEntries; e++) mem_q[e] <= ResetImage[W*e +: W];
    end else if (wr_en) begin
      mem_q[wr_idx] <= ld_data;
    end
  end

  // Gather the selected group; out-of-range selects are steered to group 0
  // so the array index stays in bounds (the result is discarded anyway).
  always_comb begin
    rd_base = sel_ok ? IdxW'(grp_sel) * IdxW'(N_adder_tree) : '0;
    rd_vec  = '0;
    for (int c = 0; c < N_adder_tree; c++) rd_vec[W*c +: W] = mem_q[rd_base + IdxW'(c)];
  end

  // Read output registers: q holds between reads, q_valid pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_err_q   <= 1'b0;
    end else begin
      q_valid_q <= rd_en;
      q_err_q   <= rd_en && !sel_ok;
      if (rd_en) q_q <= sel_ok ? rd_vec : '0;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign q_err   = q_err_q;

endmodule
